pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Fetch-stage program counter for the unicycle LEGv8 datapath. Holds the 64-bit
//   byte address driven into the instruction memory's pcAddres input and advances
//   it by 4, or to a PC-relative branch target, on every run cycle.
//   Adds a post-reset boot delay, a stall hold, a halt/fault state and a
//   fetched-instruction counter.
// PARAMETERS
//   RESET_PC    64'h0  PC value loaded on reset; must be a multiple of 4
//   MEM_BYTES   256    instruction memory size in bytes; a legal PC is <= MEM_BYTES-4
//   BOOT_DELAY  2      cycles spent in BOOT after reset release (>=1)
// PORTS
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous reset, active low
//   stall          in   1   hold PC this cycle
//   branch_taken   in   1   load the branch target this cycle
//   branch_offset  in   64  signed word offset; target = pc + (branch_offset << 2)
//   halt_req       in   1   stop fetching; sticky until reset
//   pc             out  64  registered fetch address, drives instruction memory
//   pc_plus4       out  64  combinational pc + 4
//   fetch_valid    out  1   instruction at pc is consumed this cycle
//   state          out  2   00 BOOT, 01 RUN, 10 HALT
//   pc_fault       out  1   sticky: next PC left the instruction memory range
//   fetch_count    out  32  count of cycles with fetch_valid=1, wraps at 2^32
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous): pc=RESET_PC, state=BOOT, boot counter=0,
//     pc_fault=0, fetch_count=0. fetch_valid=0 while reset is held.
//   BOOT: pc holds. Boot counter increments each cycle. All inputs are ignored.
//     After BOOT_DELAY cycles -> RUN.
//   RUN, priority order, evaluated each rising edge:
//     1. halt_req=1: -> HALT, pc holds. Overrides branch_taken and stall.
//     2. branch_taken=1: next = pc + (branch_offset<<2), 64-bit modulo 2^64.
//        Overrides stall (acts as a flush).
//     3. stall=1: pc holds.
//     4. Otherwise: next = pc + 4.
//     Range check on the unsigned value of next:
//       - next > MEM_BYTES-4: pc is not updated, pc_fault<=1, state -> HALT.
//       - next == MEM_BYTES-4: legal.
//       - The check covers negative-offset wrap-around, which gives a huge unsigned value.
//   HALT: pc, pc_fault and fetch_count frozen. Exit only by reset.
//   fetch_valid = (state==RUN) && !stall && !halt_req. This is combinational, and a
//     branch cycle still counts as a fetch.
//   fetch_count increments on each rising edge where fetch_valid=1.
//   pc is always word-aligned: reset value is aligned and every update adds a multiple of 4.
//   Reset asserted mid-operation in any state: immediate return to the reset values.
//     No partial update on the edge coincident with reset release.
//   Latency: a pc update is visible 1 cycle after the controlling inputs are sampled.
// TESTING
//   1. Reset, then release with BOOT_DELAY=2 -> pc=0 and fetch_valid=0 for 2 cycles,
//      then pc steps 0,4,8,12.
//   2. pc=8, stall=1 for 3 cycles -> pc stays 8 and fetch_count is unchanged;
//      stall=0 -> pc=12.
//   3. pc=16, branch_taken=1, offset=-2 -> pc=8. Same cycle with stall=1 -> pc=8
//      (branch wins).
//   4. pc=248, MEM_BYTES=256 -> pc=252, then a further step -> HALT, pc_fault=1,
//      pc=252 held.
//   5. pc=0, branch_taken=1, offset=-1 (wrap) -> pc_fault=1, HALT, pc=0.
//   6. Assert halt_req and branch_taken together -> HALT with pc unchanged. Then pulse
//      reset_n low mid-cycle -> pc=RESET_PC, state=BOOT, pc_fault=0, fetch_count=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch-stage program counter for the single-cycle LEGv8 datapath.
// After reset it waits in BOOT for BOOT_DELAY cycles. In RUN it advances the PC by 4,
// jumps to a PC-relative branch target, or holds the PC on a stall.
// HALT is entered on halt_req or when the next PC would leave instruction memory.
// The only way out of HALT is reset.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          MEM_BYTES  = 256,
  parameter int          BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_offset,
  input  logic        halt_req,
  output logic [63:0] pc,
  output logic [63:0] pc_plus4,
  output logic        fetch_valid,
  output logic [1:0]  state,
  output logic        pc_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  // The boot counter only has to reach BOOT_DELAY-1, so it is sized to hold that value.
  localparam int              BW        = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_DELAY - 1);
  // This is the highest word address that can still be fetched.
  localparam logic [63:0]     PC_MAX    = 64'(MEM_BYTES) - 64'd4;

  state_t        r_state;
  logic [63:0]   r_pc;
  logic          r_fault;
  logic [31:0]   r_cnt;
  logic [BW-1:0] r_boot_cnt;

  logic [63:0]   w_seq;
  logic [63:0]   w_tgt;
  logic [63:0]   w_next;
  logic          w_upd;
  logic          w_oob;
  logic          w_fetch_valid;

  assign w_seq = r_pc + 64'd4;
  // The offset counts words. Shifting it by 2 and adding modulo 2^64 makes a
  // backwards branch past 0 wrap to a huge unsigned value. The range check then catches it.
  assign w_tgt = r_pc + (branch_offset << 2);

  assign w_fetch_valid = (r_state == S_RUN) && !stall && !halt_req;

  // Choose the next PC in RUN priority order: halt, then branch (flush), then stall, then sequential.
  always_comb begin
    w_upd  = 1'b0;
    w_next = r_pc;
    if (halt_req) begin
      w_upd  = 1'b0;
    end else if (branch_taken) begin
      w_upd  = 1'b1;
      w_next = w_tgt;
    end else if (!stall) begin
      w_upd  = 1'b1;
      w_next = w_seq;
    end
  end

  // A held PC is always legal. Only a real update can take the PC out of range.
  assign w_oob = w_upd && (w_next > PC_MAX);

  // Control FSM with the PC, fault and fetch-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_cnt      <= 32'd0;
      r_boot_cnt <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_boot_cnt <= r_boot_cnt + 1'b1;
          if (r_boot_cnt == BOOT_LAST) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_fetch_valid) r_cnt <= r_cnt + 32'd1;
          if (halt_req) begin
            r_state <= S_HALT;
          end else if (w_oob) begin
            r_fault <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_pc <= w_next;
          end
        end
        default: begin
          // HALT: everything stays frozen until reset.
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_seq;
  assign fetch_valid = w_fetch_valid;
  assign state       = r_state;
  assign pc_fault    = r_fault;
  assign fetch_count = r_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Every expected value below is worked out by hand.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_offset;
  logic        halt_req;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fetch_valid;
  logic [1:0]  state;
  logic        pc_fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fails  = 0;

  pc_fetch_unit #(.RESET_PC(64'h0), .MEM_BYTES(256), .BOOT_DELAY(2)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .halt_req(halt_req), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .state(state), .pc_fault(pc_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; branch_offset = 64'd0; halt_req = 1'b0;
  endtask

  // Hold reset across two edges, release it between edges, then check the BOOT window.
  task automatic do_reset_and_boot();
    idle_inputs();
    reset_n = 1'b0;
    step(); step();
    #2 reset_n = 1'b1;
    step();
    n_checks++; if (state !== 2'b00) begin n_fails++; $display("FAIL boot1_state got %0d exp 0", state); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL boot1_fv got %0b exp 0", fetch_valid); end
    step();
    n_checks++; if (state !== 2'b01) begin n_fails++; $display("FAIL boot_done_state got %0d exp 1", state); end
    n_checks++; if (pc !== 64'd0) begin n_fails++; $display("FAIL boot_done_pc got %0d exp 0", pc); end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #3;
    n_checks++; if (pc !== 64'd0) begin n_fails++; $display("FAIL rst_pc got %0d exp 0", pc); end
    n_checks++; if (state !== 2'b00) begin n_fails++; $display("FAIL rst_state got %0d exp 0", state); end
    n_checks++; if (pc_fault !== 1'b0) begin n_fails++; $display("FAIL rst_fault got %0b exp 0", pc_fault); end
    n_checks++; if (fetch_count !== 32'd0) begin n_fails++; $display("FAIL rst_cnt got %0d exp 0", fetch_count); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL rst_fv got %0b exp 0", fetch_valid); end
    step();
    n_checks++; if (pc !== 64'd0) begin n_fails++; $display("FAIL rst_hold_pc got %0d exp 0", pc); end
  endtask

  task automatic test_boot_and_step();
    do_reset_and_boot();
    n_checks++; if (fetch_valid !== 1'b1) begin n_fails++; $display("FAIL run_fv got %0b exp 1", fetch_valid); end
    n_checks++; if (pc_plus4 !== 64'd4) begin n_fails++; $display("FAIL pc_plus4 got %0d exp 4", pc_plus4); end
    step();
    n_checks++; if (pc !== 64'd4) begin n_fails++; $display("FAIL step_pc4 got %0d exp 4", pc); end
    step();
    n_checks++; if (pc !== 64'd8) begin n_fails++; $display("FAIL step_pc8 got %0d exp 8", pc); end
    n_checks++; if (fetch_count !== 32'd2) begin n_fails++; $display("FAIL step_cnt got %0d exp 2", fetch_count); end
  endtask

  // Start at pc=8 with count 2: three stall cycles hold everything, releasing the stall steps to 12.
  task automatic test_stall();
    stall = 1'b1;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL stall_fv got %0b exp 0", fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (pc !== 64'd8) begin n_fails++; $display("FAIL stall_pc[%0d] got %0d exp 8", i, pc); end
    end
    n_checks++; if (fetch_count !== 32'd2) begin n_fails++; $display("FAIL stall_cnt got %0d exp 2", fetch_count); end
    stall = 1'b0;
    step();
    n_checks++; if (pc !== 64'd12) begin n_fails++; $display("FAIL unstall_pc got %0d exp 12", pc); end
    n_checks++; if (fetch_count !== 32'd3) begin n_fails++; $display("FAIL unstall_cnt got %0d exp 3", fetch_count); end
  endtask

  // Start at pc=12 with count 3.
  task automatic test_branch();
    step(); // pc 16, count 4
    branch_taken = 1'b1; branch_offset = -64'sd2;
    step();
    n_checks++; if (pc !== 64'd8) begin n_fails++; $display("FAIL br_pc got %0d exp 8", pc); end
    n_checks++; if (fetch_count !== 32'd5) begin n_fails++; $display("FAIL br_cnt got %0d exp 5", fetch_count); end
    idle_inputs();
    step(); step(); // pc 16, count 7
    branch_taken = 1'b1; branch_offset = -64'sd2; stall = 1'b1;
    step();
    n_checks++; if (pc !== 64'd8) begin n_fails++; $display("FAIL br_stall_pc got %0d exp 8", pc); end
    n_checks++; if (fetch_count !== 32'd7) begin n_fails++; $display("FAIL br_stall_cnt got %0d exp 7", fetch_count); end
    idle_inputs();
  endtask

  // Start at pc=8 with count 7. Jump to 248, step to the last legal word, then step past the end.
  task automatic test_fault_end();
    branch_taken = 1'b1; branch_offset = 64'd60;
    step();
    n_checks++; if (pc !== 64'd248) begin n_fails++; $display("FAIL br_fwd_pc got %0d exp 248", pc); end
    idle_inputs();
    step();
    n_checks++; if (pc !== 64'd252) begin n_fails++; $display("FAIL last_word_pc got %0d exp 252", pc); end
    n_checks++; if (state !== 2'b01) begin n_fails++; $display("FAIL last_word_state got %0d exp 1", state); end
    step();
    n_checks++; if (state !== 2'b10) begin n_fails++; $display("FAIL oob_state got %0d exp 2", state); end
    n_checks++; if (pc_fault !== 1'b1) begin n_fails++; $display("FAIL oob_fault got %0b exp 1", pc_fault); end
    n_checks++; if (pc !== 64'd252) begin n_fails++; $display("FAIL oob_pc got %0d exp 252", pc); end
    n_checks++; if (fetch_count !== 32'd10) begin n_fails++; $display("FAIL oob_cnt got %0d exp 10", fetch_count); end
    branch_taken = 1'b1; branch_offset = -64'sd4;
    step(); step();
    n_checks++; if (pc !== 64'd252) begin n_fails++; $display("FAIL halt_frozen_pc got %0d exp 252", pc); end
    n_checks++; if (fetch_count !== 32'd10) begin n_fails++; $display("FAIL halt_frozen_cnt got %0d exp 10", fetch_count); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL halt_fv got %0b exp 0", fetch_valid); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset_and_boot();
    n_checks++; if (pc_fault !== 1'b0) begin n_fails++; $display("FAIL wrap_pre_fault got %0b exp 0", pc_fault); end
    branch_taken = 1'b1; branch_offset = -64'sd1;
    step();
    n_checks++; if (pc_fault !== 1'b1) begin n_fails++; $display("FAIL wrap_fault got %0b exp 1", pc_fault); end
    n_checks++; if (state !== 2'b10) begin n_fails++; $display("FAIL wrap_state got %0d exp 2", state); end
    n_checks++; if (pc !== 64'd0) begin n_fails++; $display("FAIL wrap_pc got %0d exp 0", pc); end
    idle_inputs();
  endtask

  task automatic test_halt_and_mid_reset();
    do_reset_and_boot();
    step(); // pc 4, count 1
    halt_req = 1'b1; branch_taken = 1'b1; branch_offset = 64'd8;
    #1;
    n_checks++; if (fetch_valid !== 1'b0) begin n_fails++; $display("FAIL halt_req_fv got %0b exp 0", fetch_valid); end
    step();
    n_checks++; if (state !== 2'b10) begin n_fails++; $display("FAIL halt_state got %0d exp 2", state); end
    n_checks++; if (pc !== 64'd4) begin n_fails++; $display("FAIL halt_pc got %0d exp 4", pc); end
    n_checks++; if (pc_fault !== 1'b0) begin n_fails++; $display("FAIL halt_fault got %0b exp 0", pc_fault); end
    idle_inputs();
    step();
    n_checks++; if (state !== 2'b10) begin n_fails++; $display("FAIL halt_sticky got %0d exp 2", state); end
    n_checks++; if (fetch_count !== 32'd1) begin n_fails++; $display("FAIL halt_cnt got %0d exp 1", fetch_count); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (pc !== 64'd0) begin n_fails++; $display("FAIL mid_rst_pc got %0d exp 0", pc); end
    n_checks++; if (state !== 2'b00) begin n_fails++; $display("FAIL mid_rst_state got %0d exp 0", state); end
    n_checks++; if (pc_fault !== 1'b0) begin n_fails++; $display("FAIL mid_rst_fault got %0b exp 0", pc_fault); end
    n_checks++; if (fetch_count !== 32'd0) begin n_fails++; $display("FAIL mid_rst_cnt got %0d exp 0", fetch_count); end
    #1 reset_n = 1'b1;
    step();
    n_checks++; if (state !== 2'b00) begin n_fails++; $display("FAIL post_rst_boot got %0d exp 0", state); end
  endtask

  initial begin
    test_reset();
    test_boot_and_step();
    test_stall();
    test_branch();
    test_fault_end();
    test_wrap();
    test_halt_and_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
